// File: rtl/rom_stream_reader_pkg.sv
// Shared types and constants for the ROM burst reader and its output buffer.
// Credit limit equals buffer depth so outstanding reads can never overflow it.
package rom_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned BUF_DEPTH    = 2;
  localparam int unsigned CREDIT_LIMIT = BUF_DEPTH;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry push/pop FIFO holding {last, data}; head visible combinationally.
// Push and pop may coincide even when full; push into a full FIFO without pop is illegal.
module stream_skid_fifo
  import rom_stream_reader_pkg::*;
#(
  parameter int unsigned p_WIDTH = 9
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [p_WIDTH-1:0] push_dat_i,
  input  logic               pop_i,
  output logic [p_WIDTH-1:0] head_dat_o,
  output logic [1:0]         count_o
);

  logic [p_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         count_q;
  logic               do_pop;

  assign do_pop     = pop_i && (count_q != 2'd0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // When full, the write slot is the head being popped this same cycle.
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, do_pop};
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !do_pop && (count_q == 2'(BUF_DEPTH))));

endmodule

// File: rtl/rom_stream_reader.sv
// Burst sequencer in front of a 1-cycle synchronous ROM, emitting a valid/ready stream with last flag.
// First word 3 cycles after start, one word per cycle; reads stall on credit so backpressure is lossless.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int unsigned p_ADDR_WIDTH = 4,
  parameter int unsigned p_DATA_WIDTH = 8
) (
  input  logic                    i_CLK,
  input  logic                    i_RESET,
  input  logic                    i_START,
  input  logic [p_ADDR_WIDTH-1:0] i_START_ADDR,
  input  logic [p_ADDR_WIDTH:0]   i_LENGTH,
  output logic                    o_ROM_READ_ENABLE,
  output logic [p_ADDR_WIDTH-1:0] o_ROM_ADDRESS,
  input  logic [p_DATA_WIDTH-1:0] i_ROM_DATA,
  output logic                    o_VALID,
  output logic [p_DATA_WIDTH-1:0] o_DATA,
  output logic                    o_LAST,
  input  logic                    i_READY,
  output logic                    o_BUSY,
  output logic                    o_DONE
);

  localparam int unsigned LW = p_ADDR_WIDTH + 1;
  localparam logic [LW-1:0] MAX_LEN = {1'b1, {p_ADDR_WIDTH{1'b0}}};

  state_e                    state_q, state_d;
  logic [p_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LW-1:0]             remaining_q, remaining_d;
  logic                      inflight_q, inflight_d;
  logic                      inflight_last_q, inflight_last_d;

  logic [1:0]                buf_count;
  logic [p_DATA_WIDTH:0]     buf_head;
  logic                      pop;
  logic                      issue;
  logic [2:0]                credit_used;

  stream_skid_fifo #(
    .p_WIDTH (p_DATA_WIDTH + 1)
  ) u_buf (
    .clk_i      (i_CLK),
    .rst_i      (i_RESET),
    .push_i     (inflight_q),
    .push_dat_i ({inflight_last_q, i_ROM_DATA}),
    .pop_i      (pop),
    .head_dat_o (buf_head),
    .count_o    (buf_count)
  );

  assign o_VALID = (buf_count != 2'd0);
  assign o_DATA  = o_VALID ? buf_head[p_DATA_WIDTH-1:0] : '0;
  assign o_LAST  = o_VALID && buf_head[p_DATA_WIDTH];
  assign pop     = o_VALID && i_READY;

  // Words already buffered or on their way, net of the one leaving this cycle.
  assign credit_used = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue       = (state_q == ISSUE) && (credit_used < 3'(CREDIT_LIMIT));

  assign o_ROM_READ_ENABLE = issue;
  assign o_ROM_ADDRESS     = addr_q;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == LW'(1));
    o_BUSY          = 1'b0;
    o_DONE          = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_START) begin
          if (i_LENGTH == '0) begin
            state_d = DONE;
          end else begin
            state_d     = ISSUE;
            addr_d      = i_START_ADDR;
            remaining_d = (i_LENGTH > MAX_LEN) ? MAX_LEN : i_LENGTH;
          end
        end
      end
      ISSUE: begin
        o_BUSY = 1'b1;
        if (issue) begin
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - LW'(1);
          if (remaining_q == LW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        o_BUSY = 1'b1;
        if (pop && o_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        o_BUSY  = 1'b1;
        o_DONE  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: table of bursts against a registered ROM model and a word scoreboard.
module tb_rom_stream_reader;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic          rom_re;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          valid;
  logic [DW-1:0] data;
  logic          last;
  logic          ready;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  rom_stream_reader #(.p_ADDR_WIDTH(AW), .p_DATA_WIDTH(DW)) dut (
    .i_CLK             (clk),
    .i_RESET           (rst),
    .i_START           (start),
    .i_START_ADDR      (start_addr),
    .i_LENGTH          (length),
    .o_ROM_READ_ENABLE (rom_re),
    .o_ROM_ADDRESS     (rom_addr),
    .i_ROM_DATA        (rom_data),
    .o_VALID           (valid),
    .o_DATA            (data),
    .o_LAST            (last),
    .i_READY           (ready),
    .o_BUSY            (busy),
    .o_DONE            (done)
  );

  // ROM model: registered output, zeros when not enabled.
  logic [DW-1:0] rom_mem [16];
  initial for (int i = 0; i < 16; i++) rom_mem[i] = 8'(i + 16);
  always @(posedge clk) rom_data <= rom_re ? rom_mem[rom_addr] : '0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] sa;
    logic [4:0] len;
    int         mode;       // 0: ready=1, 1: ready 1,0,0 pattern, 2: ready=0 until cycle 12
    bit         restart;    // pulse i_START again while issuing
    int         exp_words;
    logic [7:0] exp_last;
    int         exp_first;
    int         exp_done;   // -1: cycle depends on backpressure
  } vec_t;

  vec_t vecs[7];

  logic [DW:0]   exp_q[$];
  bit            mon_en = 0;
  bit            chk_done = 0;
  int            reads = 0;
  int            hs_done = 0;
  logic [AW-1:0] exp_addr = '0;
  bit            stall_pend = 0;
  logic [DW-1:0] stall_dat = '0;
  logic          stall_last = 0;
  bit            prev_last_hs = 0;
  logic [DW-1:0] last_dat = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rom_re) begin
        chk("credit", ((reads - hs_done - ((valid && ready) ? 1 : 0)) < 2) ? 1 : 0, 1);
        chk("rom_addr", rom_addr, exp_addr);
        exp_addr = exp_addr + 1'b1;
        reads++;
      end
      if (stall_pend) begin
        chk("stall_valid", valid, 1);
        chk("stall_data", data, stall_dat);
        chk("stall_last", last, stall_last);
      end
      stall_pend = valid && !ready;
      stall_dat  = data;
      stall_last = last;
      if (chk_done) chk("done_timing", done, prev_last_hs);
      prev_last_hs = valid && ready && last;
      if (valid && ready) begin
        chk("sb_has_word", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          chk("word_data", data, e[DW-1:0]);
          chk("word_last", last, e[DW]);
        end
        hs_done++;
        last_dat = data;
      end
    end
  end

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 3 == 0);
      default: return (c >= 12);
    endcase
  endfunction

  task automatic prime(input logic [3:0] sa, input logic [4:0] len);
    int n;
    n = (len > 16) ? 16 : int'(len);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), 8'(8'h10 + ((int'(sa) + i) % 16))});
    reads = 0; hs_done = 0; exp_addr = sa; stall_pend = 0; prev_last_hs = 0;
    chk_done = 1; mon_en = 1;
  endtask

  task automatic run_burst(input int k);
    vec_t v;
    int first, done_c, c;
    v = vecs[k];
    prime(v.sa, v.len);
    @(posedge clk); #1;
    start = 1; start_addr = v.sa; length = v.len; ready = ready_for(v.mode, 0);
    first = -1; done_c = -1; c = 0;
    while (done_c < 0 && c < 300) begin
      @(posedge clk); #1;
      c++;
      start = v.restart && (c == 2);
      if (start) begin start_addr = 4'hA; length = 5'd2; end
      ready = ready_for(v.mode, c);
      if (valid && first < 0) first = c;
      if (done) done_c = c;
      if (v.mode == 2 && c == 10) begin
        chk("bp_hold_re", rom_re, 0);
        chk("bp_hold_addr", rom_addr, 4'(v.sa + 4'd2));
        chk("bp_hold_valid", valid, 1);
      end
    end
    chk("done_seen", (done_c >= 0) ? 1 : 0, 1);
    if (v.exp_done >= 0) chk("done_cycle", done_c, v.exp_done);
    chk("first_valid_cycle", first, v.exp_first);
    chk("busy_in_done", busy, 1);
    @(posedge clk); #1;
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("word_count", hs_done, v.exp_words);
    chk("last_data", last_dat, v.exp_last);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_re"}, rom_re, 0);
    chk({tag, "_addr"}, rom_addr, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int c;
    vecs[0] = '{4'h3, 5'd4,  0, 1'b0, 4,  8'h16, 3, 7};
    vecs[1] = '{4'hE, 5'd4,  0, 1'b0, 4,  8'h11, 3, 7};
    vecs[2] = '{4'h5, 5'd6,  1, 1'b0, 6,  8'h1A, 3, -1};
    vecs[3] = '{4'h7, 5'd31, 0, 1'b0, 16, 8'h16, 3, 19};
    vecs[4] = '{4'h9, 5'd16, 2, 1'b0, 16, 8'h18, 3, -1};
    vecs[5] = '{4'h2, 5'd5,  0, 1'b1, 5,  8'h16, 3, 8};
    vecs[6] = '{4'hF, 5'd1,  0, 1'b0, 1,  8'h1F, 3, 4};

    rst = 1; start = 0; start_addr = '0; length = '0; ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all_zero("reset");
    rst = 0;

    for (int k = 0; k < 7; k++) run_burst(k);

    // Zero length: immediate one-cycle DONE, no ROM access.
    prime(4'h5, 5'd0);
    chk_done = 0;
    @(posedge clk); #1;
    start = 1; start_addr = 4'h5; length = 5'd0; ready = 1;
    @(posedge clk); #1;
    start = 0;
    chk("zl_done", done, 1);
    chk("zl_busy", busy, 1);
    chk("zl_re", rom_re, 0);
    @(posedge clk); #1;
    chk("zl_done_once", done, 0);
    chk("zl_busy_after", busy, 0);
    chk("zl_valid", valid, 0);
    chk("zl_reads", reads, 0);

    // Reset one cycle after the second handshake of an 8-word burst.
    prime(4'h0, 5'd8);
    @(posedge clk); #1;
    start = 1; start_addr = 4'h0; length = 5'd8; ready = 1;
    c = 0;
    while (hs_done < 2 && c < 50) begin
      @(posedge clk); #1;
      c++;
      start = 0;
    end
    chk("rst_two_handshakes", hs_done, 2);
    rst = 1; mon_en = 0;
    @(posedge clk); #1;
    rst = 0;
    chk_all_zero("midrst");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", done, 0);
      chk("midrst_no_valid", valid, 0);
      chk("midrst_no_read", rom_re, 0);
    end
    run_burst(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
